// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator controller front end.
//   N_FLOORS_DEFAULT        : default number of floors (call vector width)
//   DEBOUNCE_CYCLES_DEFAULT : default debounce window in clock cycles
//   call_kind_t             : identifies the source of a call (car, hall up, hall down)
// ----------------------------------------------------------------------------
package elevator_pkg;

   localparam int unsigned N_FLOORS_DEFAULT        = 10;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

   typedef enum logic [1:0] {
      CAR  = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } call_kind_t;

endpackage : elevator_pkg

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One call input: 2-flop synchroniser, debounce counter, rising-edge pulse.
// Ports:
//   clock      in  system clock
//   reset      in  asynchronous active-low reset
//   raw        in  raw asynchronous button level
//   pulse      out registered one-cycle pulse on an accepted 0->1 change
//   pulse_next out next-state value of pulse (lets the parent register an OR
//                  that lines up with pulse in the same cycle)
// ----------------------------------------------------------------------------
module debounce_channel
   import elevator_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic pulse,
   output logic pulse_next
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb;
   logic [CW-1:0] r_cnt;
   logic          r_pulse;

   logic          w_differs;
   logic          w_accept;
   logic          w_deb_next;
   logic [CW-1:0] w_cnt_next;
   logic          w_pulse_next;

   assign w_differs = (r_sync2 != r_deb);
   assign w_accept  = w_differs && (r_cnt == CNT_LAST);

   // Counter restarts on any bounce back to the accepted level.
   always_comb begin
      w_deb_next = r_deb;
      w_cnt_next = '0;
      if (w_accept) begin
         w_deb_next = r_sync2;
         w_cnt_next = '0;
      end else if (w_differs) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   // Only the 0->1 acceptance produces a pulse; releases are silent.
   assign w_pulse_next = w_accept & r_sync2;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         r_deb   <= w_deb_next;
         r_cnt   <= w_cnt_next;
         r_pulse <= w_pulse_next;
      end
   end

   assign pulse      = r_pulse;
   assign pulse_next = w_pulse_next;

endmodule : debounce_channel

// File: rtl/call_input_conditioner.sv
// ----------------------------------------------------------------------------
// call_input_conditioner
// Turns raw car/hall call buttons into clean single-cycle press pulses.
// Hall up at the top floor and hall down at the bottom floor cannot exist and
// are tied low.
// Ports:
//   clock         in  system clock
//   reset         in  asynchronous active-low reset
//   buttons       in  [N_FLOORS] raw car-panel buttons
//   ups           in  [N_FLOORS] raw hall up calls
//   downs         in  [N_FLOORS] raw hall down calls
//   button_pulse  out [N_FLOORS] car-button press pulses
//   up_pulse      out [N_FLOORS] up-call press pulses (top bit always 0)
//   down_pulse    out [N_FLOORS] down-call press pulses (bit 0 always 0)
//   any_pulse     out OR of all pulse bits, aligned with them
// ----------------------------------------------------------------------------
module call_input_conditioner
   import elevator_pkg::*;
#(
   parameter int unsigned N_FLOORS        = N_FLOORS_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] buttons,
   input  logic [N_FLOORS-1:0] ups,
   input  logic [N_FLOORS-1:0] downs,
   output logic [N_FLOORS-1:0] button_pulse,
   output logic [N_FLOORS-1:0] up_pulse,
   output logic [N_FLOORS-1:0] down_pulse,
   output logic                any_pulse
);

   logic [N_FLOORS-1:0] w_btn_next;
   logic [N_FLOORS-1:0] w_up_next;
   logic [N_FLOORS-1:0] w_dn_next;
   logic                r_any_pulse;
   logic                w_unused_masked;

   // Masked inputs are physically impossible calls; deliberately ignored.
   assign w_unused_masked = ^{ups[N_FLOORS-1], downs[0]};

   for (genvar g = 0; g < N_FLOORS; g++) begin : g_floor
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_car (
         .clock      (clock),
         .reset      (reset),
         .raw        (buttons[g]),
         .pulse      (button_pulse[g]),
         .pulse_next (w_btn_next[g])
      );

      if (g < N_FLOORS - 1) begin : g_up
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_up (
            .clock      (clock),
            .reset      (reset),
            .raw        (ups[g]),
            .pulse      (up_pulse[g]),
            .pulse_next (w_up_next[g])
         );
      end else begin : g_up_masked
         assign up_pulse[g]  = 1'b0;
         assign w_up_next[g] = 1'b0;
      end

      if (g > 0) begin : g_dn
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_dn (
            .clock      (clock),
            .reset      (reset),
            .raw        (downs[g]),
            .pulse      (down_pulse[g]),
            .pulse_next (w_dn_next[g])
         );
      end else begin : g_dn_masked
         assign down_pulse[g] = 1'b0;
         assign w_dn_next[g]  = 1'b0;
      end
   end

   // Registered from next-state pulses so it is high in the same cycle as them.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_any_pulse <= 1'b0;
      end else begin
         r_any_pulse <= |{w_btn_next, w_up_next, w_dn_next};
      end
   end

   assign any_pulse = r_any_pulse;

endmodule : call_input_conditioner

// File: tb/tb_call_input_conditioner.sv
module tb_call_input_conditioner;

   localparam int N = 10;
   localparam int D = 4;

   logic         clock;
   logic         reset;
   logic [N-1:0] buttons, ups, downs;
   logic [N-1:0] button_pulse, up_pulse, down_pulse;
   logic         any_pulse;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 0;

   typedef struct {
      int           at;
      logic [N-1:0] b;
      logic [N-1:0] u;
      logic [N-1:0] d;
   } exp_t;

   exp_t sb[$];

   call_input_conditioner #(
      .N_FLOORS        (N),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .buttons      (buttons),
      .ups          (ups),
      .downs        (downs),
      .button_pulse (button_pulse),
      .up_pulse     (up_pulse),
      .down_pulse   (down_pulse),
      .any_pulse    (any_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Input changed now -> first sampling edge is cyc+1 -> pulse visible after edge cyc+1+1+D.
   task automatic expect_pulse(input logic [N-1:0] b, input logic [N-1:0] u,
                               input logic [N-1:0] d);
      exp_t e;
      e.at = cyc + D + 2;
      e.b  = b;
      e.u  = u;
      e.d  = d;
      sb.push_back(e);
   endtask

   // Monitor: pops an expectation whenever the DUT presents any pulse.
   always @(negedge clock) begin
      if (mon_en) begin
         chk("any_vs_or", 64'(any_pulse), 64'(|{button_pulse, up_pulse, down_pulse}));
         chk("masked_bits", 64'({up_pulse[N-1], down_pulse[0]}), 64'd0);
         if (any_pulse || (|{button_pulse, up_pulse, down_pulse})) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", 64'({button_pulse, up_pulse, down_pulse}), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pulse_cycle", 64'(cyc), 64'(e.at));
               chk("pulse_bits", 64'({button_pulse, up_pulse, down_pulse}),
                   64'({e.b, e.u, e.d}));
            end
         end
      end
   end

   initial begin
      buttons = '0;
      ups     = '0;
      downs   = '0;
      reset   = 1'b0;
      #2;
      chk("reset_state", 64'({button_pulse, up_pulse, down_pulse, any_pulse}), 64'd0);
      step(3);
      reset  = 1'b1;
      mon_en = 1'b1;
      step(5);

      // Single car button held 10 cycles.
      buttons = 10'b0000010000;
      expect_pulse(10'b0000010000, '0, '0);
      step(10);
      buttons = '0;
      step(15);

      // Bouncy up call: 2 high, 1 low, 2 high -> never accepted.
      ups[3] = 1'b1; step(2);
      ups[3] = 1'b0; step(1);
      ups[3] = 1'b1; step(2);
      ups[3] = 1'b0; step(15);

      // Long hold then release: one pulse only.
      downs[7] = 1'b1;
      expect_pulse('0, '0, 10'b0010000000);
      step(100);
      downs[7] = 1'b0;
      step(15);

      // Impossible hall calls stay masked.
      ups[9]   = 1'b1;
      downs[0] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         chk("masked_hold", 64'({up_pulse[9], down_pulse[0], any_pulse}), 64'd0);
         step(1);
      end
      ups[9]   = 1'b0;
      downs[0] = 1'b0;
      step(15);

      // Simultaneous presses on different kinds.
      buttons[2] = 1'b1;
      ups[5]     = 1'b1;
      expect_pulse(10'b0000000100, 10'b0000100000, '0);
      step(12);
      buttons[2] = 1'b0;
      ups[5]     = 1'b0;
      step(15);

      // Reset mid-count discards the press; held input re-pulses after release.
      buttons[8] = 1'b1;
      step(3);
      reset = 1'b0;
      #1;
      chk("reset_mid", 64'({button_pulse, up_pulse, down_pulse, any_pulse}), 64'd0);
      step(1);
      reset = 1'b1;
      expect_pulse(10'b0100000000, '0, '0);
      step(15);
      buttons[8] = 1'b0;
      step(15);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_call_input_conditioner

// File: doc/call_input_conditioner.md
# call_input_conditioner

Front-end stage for the elevator controller: it takes the raw asynchronous hall and car call inputs (`buttons`, `ups`, `downs`) and converts them into clean single-cycle press pulses. Each input is synchronised, debounced and edge-detected before the pulses feed the request register. The block also masks the two physically impossible hall calls: up at the top floor and down at the bottom floor. It sits between the top-level pins and the request-register stage inside `top_design`.

## Interface
- `N_FLOORS`, 10, number of floors; this is the width of every call vector.
- `DEBOUNCE_CYCLES`, 4, number of consecutive stable cycles required before a level change is accepted; legal range 1..255.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `buttons`  in  N_FLOORS  raw car-panel floor buttons, active-high, asynchronous.
- `ups`  in  N_FLOORS  raw hall up-call buttons, active-high, asynchronous.
- `downs`  in  N_FLOORS  raw hall down-call buttons, active-high, asynchronous.
- `button_pulse`  out  N_FLOORS  one-cycle pulse per accepted car-button press.
- `up_pulse`  out  N_FLOORS  one-cycle pulse per accepted up call; bit N_FLOORS-1 is tied to 0.
- `down_pulse`  out  N_FLOORS  one-cycle pulse per accepted down call; bit 0 is tied to 0.
- `any_pulse`  out  1  registered OR of all pulse bits in the same cycle.

## Operation
- There are 3·N_FLOORS identical channels. Each channel has:
  - a 2-flop synchroniser (`sync1`, `sync2`);
  - a debounced level `deb`;
  - a counter `cnt` of width $clog2(DEBOUNCE_CYCLES+1).
- Per cycle, for each channel:
  - If `sync2 == deb`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `deb` ← `sync2` and `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
- Pulse generation: `pulse` ← 1 only in the cycle in which `deb` flips 0→1. It is 0 otherwise, including on 1→0 flips.
- A held press produces exactly one pulse regardless of how long it is held. A new pulse requires an accepted release followed by an accepted press.
- Glitches shorter than DEBOUNCE_CYCLES cycles at `sync2` never change `deb`. The counter restarts from 0 on every bounce.
- Masking: channels `ups[N_FLOORS-1]` and `downs[0]` are not instantiated. Their outputs are the constant 0.
- Channels are independent. Simultaneous presses on any set of inputs produce their pulses in the same cycle.
- With DEBOUNCE_CYCLES=1, a raw input held high across one rising edge produces exactly one pulse. Top-level simulation uses this setting.

## Timing
- Reset (`reset`=0, asynchronous) clears `sync1`, `sync2`, `deb`, `cnt`, all pulse outputs and `any_pulse` to 0 immediately.
- After reset deasserts, an input that is already high is treated as a new press. It pulses after the normal latency.
- Latency: raw input stable high from before edge k → `sync2`=1 after edge k+1 → `deb` flips at edge k+1+D → pulse is high between edges k+1+D and k+2+D.
  - Total latency is D+2 cycles, where D = DEBOUNCE_CYCLES.
- `any_pulse` is high in exactly the same cycle as the pulse bits (it is not delayed).
- Reset asserted mid-count: the count is lost and no pulse is emitted for that press. After release, the press must again be stable for D cycles.
- Pulse width is always exactly 1 cycle. Back-to-back pulses on one channel are at least 2·D cycles apart.

## Structure
- Shared package `elevator_pkg`:
  - `N_FLOORS_DEFAULT`;
  - the `call_kind_t` enum (CAR, UP, DOWN);
  - the DEBOUNCE_CYCLES default.
- Sub-module `debounce_channel` (parameter DEBOUNCE_CYCLES; ports `clock`, `reset`, `raw`, `pulse`) holds the sync, counter and edge logic.
- The top instantiates `debounce_channel` with generate loops. It ties the two masked outputs low and registers `any_pulse` from the next-state pulse values.

## Test plan
- D=4, `buttons`=10'b0000010000 held 10 cycles from edge k → `button_pulse[4]`=1 only in the cycle after edge k+5, and `any_pulse` is 1 in the same cycle; all other bits stay 0.
- D=4, `ups[3]` high for 2 cycles, low for 1 cycle, high for 2 cycles → no pulse on `up_pulse[3]` at any time.
- D=4, `downs[7]` held for 100 cycles then released → exactly one pulse 6 cycles after the press, and no pulse on release.
- `ups[9]`=1 and `downs[0]`=1 held for 50 cycles → `up_pulse[9]`, `down_pulse[0]` and `any_pulse` stay 0 throughout.
- `buttons[2]` and `ups[5]` rise on the same edge → both pulse in the same cycle.
- `buttons[8]` held; `reset`=0 for 1 cycle at k+3, then held high → no pulse at k+5, and one pulse D+2 cycles after `reset` returns to 1.
